// File: rtl/npc_pkg.sv
// Shared NPC core definitions used by the fetch stage: widths, reset vector and
// the fetch FSM state encoding.
package npc_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          INST_BYTES = 4;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT
    } ifu_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch program counter: reset vector, redirect target, or sequential advance.
// A redirect always wins over the sequential advance.
module ifu_pc_reg
    import npc_pkg::*;
#(
    parameter int              XLEN     = npc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc + XLEN'(INST_BYTES);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch stage: one outstanding imem request, a held
// {pc, inst} slot towards decode, and redirect squashing.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int              XLEN     = npc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
);

    ifu_state_t      state;
    logic            drop;
    logic            advance;
    logic [XLEN-1:0] pc;

    // The PC only steps forward when a live response is handed to decode.
    assign advance = (state == S_WAIT) && imem_resp_valid && !drop && !redirect_valid;

    ifu_pc_reg #(
        .XLEN    (XLEN),
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (advance),
        .pc            (pc)
    );

    assign imem_req_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_REQ;
            drop           <= 1'b0;
            imem_req_valid <= 1'b1;
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_inst        <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state          <= S_WAIT;
                        imem_req_valid <= 1'b0;
                        drop           <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    // A redirect seen before the response marks it stale.
                    if (imem_resp_valid) begin
                        drop <= 1'b0;
                        if (drop || redirect_valid) begin
                            state          <= S_REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            id_inst  <= imem_resp_data;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                            state    <= S_OUT;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid || id_ready) begin
                        id_valid       <= 1'b0;
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (id_valid && id_ready && !redirect_valid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (id_valid && !id_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule
